emu_scan_dma_ctrl: RTL and testbench
====================================

// Module: emu_scan_dma_ctrl
// PURPOSE
//   Sequences one scan-chain save/restore transfer between the emulator scan chain and host memory.
//   Started by the system-control DMA start pulse (SCAN_CTRL write); reports dma_running back to it.
//   Save streams chain words out to memory as bursts. Load streams memory words into the chain.
//   Sits between the system controller, the scan chain and a simplified burst memory port.
// PARAMETERS
//   ADDR_WIDTH   32  memory byte-address width
//   DATA_WIDTH   64  chain word / memory beat width; power of 2, >=8
//   CHAIN_WORDS  20  words per full chain transfer; >=1
//   MAX_BURST    16  max beats per burst; 1..256
// PORTS
//   host_clk        in   1    clock
//   host_rst        in   1    sync reset, active-high
//   dma_start       in   1    1-cycle start pulse
//   dma_direction   in   1    0=save (chain->mem), 1=load (mem->chain)
//   dma_base        in   AW   transfer start byte address
//   dma_running     out  1    transfer in progress
//   dma_done        out  1    1-cycle pulse at completion
//   scan_en         out  1    advance chain by one word this cycle
//   scan_din        out  DW   word shifted into chain (load)
//   scan_dout       in   DW   word presented at chain output (save)
//   mem_req_valid   out  1    burst request valid
//   mem_req_ready   in   1    burst request accepted
//   mem_req_write   out  1    1=write burst, 0=read burst
//   mem_req_addr    out  AW   burst start byte address
//   mem_req_len     out  8    beats-1
//   mem_wvalid      out  1    write beat valid
//   mem_wready      in   1    write beat accepted
//   mem_wdata       out  DW   write beat data
//   mem_wlast       out  1    last beat of burst
//   mem_bvalid      in   1    write burst response (always accepted)
//   mem_rvalid      in   1    read beat valid
//   mem_rready      out  1    read beat accepted
//   mem_rdata       in   DW   read beat data
// BEHAVIOUR
//   - Reset: FSM=IDLE. All outputs 0 (dma_running, dma_done, scan_en, mem_*valid, mem_rready, addr/len/data).
//   - FSM: IDLE -> REQ -> DATA -> (save: RESP) -> REQ | DONE -> IDLE.
//   - IDLE: on dma_start, latch dir=dma_direction and addr=dma_base; remain=CHAIN_WORDS; go REQ next cycle.
//     dma_running=1 from the cycle after dma_start, through DONE.
//   - dma_start while not IDLE is ignored; dma_direction/dma_base are sampled only at start.
//   - REQ: mem_req_valid=1; len=min(remain,MAX_BURST)-1; mem_req_write=~dir.
//     addr/len/write are held stable until mem_req_ready. On handshake go DATA; beat=0.
//   - DATA save:
//     mem_wvalid=1; mem_wdata=scan_dout (combinational);
//     scan_en=mem_wvalid&mem_wready; mem_wlast=(beat==len).
//     Beat on last -> RESP.
//   - DATA load:
//     mem_rready=1; scan_en=mem_rvalid; scan_din=mem_rdata (combinational).
//     The beat counter is authoritative and mem_rlast is not used. Beat on last -> burst end.
//   - RESP (save only): wait mem_bvalid. Only one burst is outstanding; the next REQ issues after the response.
//   - Burst end: remain-=len+1; addr+=(len+1)*DW/8 (wraps mod 2^AW).
//     If remain==0 -> DONE, else -> REQ.
//   - DONE: dma_done=1 for one cycle, dma_running=0 next cycle, FSM -> IDLE.
//   - Exactly CHAIN_WORDS scan_en pulses per transfer; no scan_en outside DATA.
//   - dma_base is caller-aligned to MAX_BURST*DW/8; the block does no 4KB splitting.
//   - host_rst mid-transfer: immediate IDLE; valids drop in the reset cycle; partial data is abandoned.
// STRUCTURE
//   - Shared package (emu_scan_pkg): FSM state enum (IDLE, REQ, DATA, RESP, DONE) and BEAT_BYTES = DW/8.
//   - Single module, no sub-modules. The counters (remain, beat, addr) are inline registers.
// TESTING
//   1. Save, base 0x1000, DW=64, CHAIN_WORDS=20, MAX_BURST=16:
//      bursts (0x1000, len 15) and (0x1080, len 3); 20 scan_en; dma_done once.
//   2. Load, same config, rvalid with random gaps:
//      scan_din sequence equals the memory image; 20 scan_en; mem_req_write=0.
//   3. Save with mem_wready/mem_req_ready/mem_bvalid back-pressure of 0-5 cycles:
//      no lost or duplicated beat; second REQ only after the first bvalid.
//   4. dma_start pulsed again mid-transfer with a different base/direction:
//      ignored, and the transfer completes unchanged.
//   5. host_rst during DATA of burst 2:
//      all valids 0 in the reset cycle. A new start after reset begins from a fresh base with 20 words.
//   6. CHAIN_WORDS=1, MAX_BURST=1: one burst of len 0, wlast=1 on the first beat, dma_done follows bvalid.

Source files
------------

// File: rtl/emu_scan_pkg.sv
// Shared definitions for the emulator scan-chain DMA controller.
//   state_t    : sequencer states (IDLE, REQ, DATA, RESP, DONE)
//   beat_bytes : bytes carried by one memory beat for a given data width
package emu_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DATA,
        RESP,
        DONE
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 64;

    // BEAT_BYTES = DW/8; a function so each instance derives it from its own DW.
    function automatic int beat_bytes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/emu_scan_dma_ctrl_if.sv
// Simplified burst memory port used by the scan DMA controller.
//   request channel : mem_req_valid/ready, mem_req_write, mem_req_addr, mem_req_len (beats-1)
//   write channel   : mem_wvalid/wready, mem_wdata, mem_wlast
//   write response  : mem_bvalid (always accepted)
//   read channel    : mem_rvalid/rready, mem_rdata
// master = controller side, slave = memory side.
interface emu_scan_dma_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [7:0]            mem_req_len;
    logic                  mem_wvalid;
    logic                  mem_wready;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_wlast;
    logic                  mem_bvalid;
    logic                  mem_rvalid;
    logic                  mem_rready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_len,
        output mem_wvalid, mem_wdata, mem_wlast, mem_rready,
        input  mem_req_ready, mem_wready, mem_bvalid, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_len,
        input  mem_wvalid, mem_wdata, mem_wlast, mem_rready,
        output mem_req_ready, mem_wready, mem_bvalid, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/emu_scan_dma_ctrl.sv
// Scan-chain save/restore DMA sequencer.
// Moves CHAIN_WORDS words between the emulator scan chain and host memory as
// bursts of up to MAX_BURST beats, one burst outstanding at a time.
// Ports:
//   host_clk, host_rst        : clock, synchronous active-high reset
//   dma_start/direction/base  : start pulse, 0=save 1=load, start byte address
//   dma_running, dma_done     : busy flag, one-cycle completion pulse
//   scan_en, scan_din         : advance chain / word shifted in (load)
//   scan_dout                 : word at chain output (save)
//   mem                       : burst memory port (master side)
import emu_scan_pkg::*;

module emu_scan_dma_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int CHAIN_WORDS = 20,
    parameter int MAX_BURST   = 16
) (
    input  logic                  host_clk,
    input  logic                  host_rst,
    input  logic                  dma_start,
    input  logic                  dma_direction,
    input  logic [ADDR_WIDTH-1:0] dma_base,
    output logic                  dma_running,
    output logic                  dma_done,
    output logic                  scan_en,
    output logic [DATA_WIDTH-1:0] scan_din,
    input  logic [DATA_WIDTH-1:0] scan_dout,
    emu_scan_dma_ctrl_if.master   mem
);

    localparam int BEAT_BYTES = beat_bytes(DATA_WIDTH);
    localparam int RW         = $clog2(CHAIN_WORDS + 1);

    state_t                state_reg, state_next;
    logic                  dir_reg, dir_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [RW-1:0]         remain_reg, remain_next;
    logic [7:0]            beat_reg, beat_next;

    logic [8:0]            burst_words;   // 1..256 beats in the current burst
    logic [7:0]            burst_len;     // beats-1
    logic [RW-1:0]         remain_after;
    logic                  burst_end;

    // remain only changes at burst end, so burst length stays stable through REQ/DATA/RESP.
    always_comb begin
        if (32'(remain_reg) > MAX_BURST) begin
            burst_words = 9'(MAX_BURST);
        end else begin
            burst_words = 9'(remain_reg);
        end
        burst_len    = 8'(burst_words - 9'd1);
        remain_after = remain_reg - RW'(burst_words);
    end

    always_ff @(posedge host_clk) begin
        if (host_rst) begin
            state_reg  <= IDLE;
            dir_reg    <= 1'b0;
            addr_reg   <= '0;
            remain_reg <= '0;
            beat_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            dir_reg    <= dir_next;
            addr_reg   <= addr_next;
            remain_reg <= remain_next;
            beat_reg   <= beat_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        dir_next          = dir_reg;
        addr_next         = addr_reg;
        remain_next       = remain_reg;
        beat_next         = beat_reg;
        burst_end         = 1'b0;
        dma_running       = 1'b0;
        dma_done          = 1'b0;
        scan_en           = 1'b0;
        scan_din          = '0;
        mem.mem_req_valid = 1'b0;
        mem.mem_req_write = 1'b0;
        mem.mem_req_addr  = '0;
        mem.mem_req_len   = '0;
        mem.mem_wvalid    = 1'b0;
        mem.mem_wdata     = '0;
        mem.mem_wlast     = 1'b0;
        mem.mem_rready    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (dma_start) begin
                    dir_next    = dma_direction;
                    addr_next   = dma_base;
                    remain_next = RW'(CHAIN_WORDS);
                    state_next  = REQ;
                end
            end
            REQ: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_req_write = ~dir_reg;
                mem.mem_req_addr  = addr_reg;
                mem.mem_req_len   = burst_len;
                if (mem.mem_req_ready) begin
                    beat_next  = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (!dir_reg) begin
                    // Save: the chain word goes straight onto the write bus and the
                    // chain advances only when the beat is accepted.
                    mem.mem_wvalid = 1'b1;
                    mem.mem_wdata  = scan_dout;
                    mem.mem_wlast  = (beat_reg == burst_len);
                    scan_en        = mem.mem_wready;
                    if (mem.mem_wready) begin
                        if (beat_reg == burst_len) begin
                            state_next = RESP;
                        end else begin
                            beat_next = beat_reg + 8'd1;
                        end
                    end
                end else begin
                    // Load: beat counter decides the burst end; no rlast needed.
                    mem.mem_rready = 1'b1;
                    scan_en        = mem.mem_rvalid;
                    scan_din       = mem.mem_rdata;
                    if (mem.mem_rvalid) begin
                        if (beat_reg == burst_len) begin
                            burst_end = 1'b1;
                        end else begin
                            beat_next = beat_reg + 8'd1;
                        end
                    end
                end
            end
            RESP: begin
                if (mem.mem_bvalid) begin
                    burst_end = 1'b1;
                end
            end
            DONE: begin
                dma_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (burst_end) begin
            remain_next = remain_after;
            addr_next   = addr_reg + ADDR_WIDTH'(burst_words) * ADDR_WIDTH'(BEAT_BYTES);
            state_next  = (remain_after == '0) ? DONE : REQ;
        end

        dma_running = (state_reg != IDLE);

        // Outputs drop in the very cycle reset is asserted, not one cycle later.
        if (host_rst) begin
            dma_running       = 1'b0;
            dma_done          = 1'b0;
            scan_en           = 1'b0;
            scan_din          = '0;
            mem.mem_req_valid = 1'b0;
            mem.mem_req_write = 1'b0;
            mem.mem_req_addr  = '0;
            mem.mem_req_len   = '0;
            mem.mem_wvalid    = 1'b0;
            mem.mem_wdata     = '0;
            mem.mem_wlast     = 1'b0;
            mem.mem_rready    = 1'b0;
        end
    end

endmodule

// File: tb/tb_emu_scan_dma_ctrl.sv
// Scoreboard bench for emu_scan_dma_ctrl: expected requests, write beats and
// scan_din words are queued by the stimulus; a monitor pops and compares.
module tb_emu_scan_dma_ctrl;

    logic host_clk = 1'b0;
    always #5 host_clk = ~host_clk;

    logic        host_rst, dma_start, dma_direction;
    logic [31:0] dma_base;
    logic        dma_running, dma_done, scan_en;
    logic [63:0] scan_din, scan_dout;

    logic        dma_start1, dma_running1, dma_done1, scan_en1;
    logic [63:0] scan_din1, scan_dout1;

    emu_scan_dma_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) m0 ();
    emu_scan_dma_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) m1 ();

    emu_scan_dma_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .CHAIN_WORDS(20), .MAX_BURST(16)) u_dut (
        .host_clk(host_clk), .host_rst(host_rst), .dma_start(dma_start),
        .dma_direction(dma_direction), .dma_base(dma_base), .dma_running(dma_running),
        .dma_done(dma_done), .scan_en(scan_en), .scan_din(scan_din),
        .scan_dout(scan_dout), .mem(m0)
    );

    emu_scan_dma_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .CHAIN_WORDS(1), .MAX_BURST(1)) u_dut1 (
        .host_clk(host_clk), .host_rst(host_rst), .dma_start(dma_start1),
        .dma_direction(1'b0), .dma_base(32'h3000), .dma_running(dma_running1),
        .dma_done(dma_done1), .scan_en(scan_en1), .scan_din(scan_din1),
        .scan_dout(scan_dout1), .mem(m1)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        wr;
    } req_t;

    req_t        exp_req[$];
    logic [64:0] exp_w[$];     // {wlast, wdata}
    logic [63:0] exp_din[$];

    int checks = 0;
    int passes = 0;
    int scan_cnt, done_cnt;
    bit outstanding;
    bit tb_load = 1'b0;
    int bp_max  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] chain_word(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [63:0] img_word(input int i);
        return 64'hA5A5_0000_0000_0000 + 64'(i * 3);
    endfunction

    // ---------------- memory + chain model (drives at negedge) ----------------
    int mphase, mdly, mbeat, mlen, chain_idx, rd_ptr;
    bit adv;

    function automatic int pick_dly(input int mx);
        return (mx == 0) ? 0 : int'($urandom_range(mx, 0));
    endfunction

    always @(negedge host_clk) begin
        m0.mem_req_ready = 1'b0;
        m0.mem_wready    = 1'b0;
        m0.mem_bvalid    = 1'b0;
        m0.mem_rvalid    = 1'b0;
        if (host_rst) begin
            mphase = 0; mdly = 0; mbeat = 0; mlen = 0;
            chain_idx = 0; rd_ptr = 0; adv = 1'b0;
            m0.mem_rdata = '0;
        end else begin
            if (adv) begin
                chain_idx++;
                adv = 1'b0;
            end
            case (mphase)
                0: if (m0.mem_req_valid) begin
                    if (mdly > 0) mdly--;
                    else begin
                        m0.mem_req_ready = 1'b1;
                        mlen   = int'(m0.mem_req_len);
                        mbeat  = 0;
                        mphase = m0.mem_req_write ? 1 : 3;
                        mdly   = pick_dly(bp_max);
                    end
                end
                1: if (m0.mem_wvalid) begin
                    if (mdly > 0) mdly--;
                    else begin
                        m0.mem_wready = 1'b1;
                        adv  = 1'b1;
                        mdly = pick_dly(bp_max);
                        if (mbeat == mlen) mphase = 2;
                        else mbeat++;
                    end
                end
                2: begin
                    if (mdly > 0) mdly--;
                    else begin
                        m0.mem_bvalid = 1'b1;
                        mphase = 0;
                        mdly   = pick_dly(bp_max);
                    end
                end
                default: begin
                    if (mdly > 0) mdly--;
                    else begin
                        m0.mem_rvalid = 1'b1;
                        m0.mem_rdata  = (rd_ptr < 20) ? img_word(rd_ptr) : 64'hDEAD;
                        rd_ptr++;
                        mdly = pick_dly(bp_max);
                        if (mbeat == mlen) mphase = 0;
                        else mbeat++;
                    end
                end
            endcase
        end
        scan_dout = (chain_idx < 20) ? chain_word(chain_idx) : 64'hBAD0;
    end

    // ---------------- monitor / scoreboard (negedge + 2) ----------------
    req_t        mr;
    logic [64:0] mw;
    logic [63:0] md;

    always @(negedge host_clk) begin
        #2;
        if (host_rst) begin
            scan_cnt = 0; done_cnt = 0; outstanding = 1'b0;
        end else begin
            if (m0.mem_req_valid && m0.mem_req_ready) begin
                $display("REQ  addr=0x%0h len=%0d write=%0d", m0.mem_req_addr, m0.mem_req_len, m0.mem_req_write);
                if (exp_req.size() == 0) begin
                    checks++;
                    $display("FAIL req_extra: got unexpected request addr 0x%0h", m0.mem_req_addr);
                end else begin
                    mr = exp_req.pop_front();
                    check("req_addr", 64'(m0.mem_req_addr), 64'(mr.addr));
                    check("req_len", 64'(m0.mem_req_len), 64'(mr.len));
                    check("req_write", 64'(m0.mem_req_write), 64'(mr.wr));
                end
                if (m0.mem_req_write) begin
                    check("req_after_bresp", 64'(outstanding), 64'd0);
                    outstanding = 1'b1;
                end
            end
            if (m0.mem_wvalid && m0.mem_wready) begin
                $display("WBEAT data=0x%0h last=%0d", m0.mem_wdata, m0.mem_wlast);
                if (exp_w.size() == 0) begin
                    checks++;
                    $display("FAIL wbeat_extra: got data 0x%0h", m0.mem_wdata);
                end else begin
                    mw = exp_w.pop_front();
                    check("wdata", m0.mem_wdata, mw[63:0]);
                    check("wlast", 64'(m0.mem_wlast), 64'(mw[64]));
                end
            end
            if (m0.mem_bvalid) outstanding = 1'b0;
            if (scan_en) begin
                scan_cnt++;
                if (tb_load) begin
                    $display("SCAN din=0x%0h", scan_din);
                    if (exp_din.size() == 0) begin
                        checks++;
                        $display("FAIL scan_extra: got din 0x%0h", scan_din);
                    end else begin
                        md = exp_din.pop_front();
                        check("scan_din", scan_din, md);
                    end
                end
            end
            if (dma_done) begin
                done_cnt++;
                $display("DONE count=%0d", done_cnt);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge host_clk);
        #2;
    endtask

    task automatic do_reset();
        host_rst = 1'b1;
        step(); step();
        host_rst = 1'b0;
    endtask

    task automatic start(input logic dir, input logic [31:0] base);
        dma_direction = dir;
        dma_base      = base;
        dma_start     = 1'b1;
        step();
        dma_start     = 1'b0;
    endtask

    task automatic push_save(input logic [31:0] base);
        exp_req.push_back('{addr: base, len: 8'd15, wr: 1'b1});
        exp_req.push_back('{addr: base + 32'h80, len: 8'd3, wr: 1'b1});
        for (int i = 0; i < 20; i++) exp_w.push_back({(i == 15 || i == 19), chain_word(i)});
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
        for (int i = 0; i < 6; i++) step();
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check({tag, "_scan_count"}, 64'(scan_cnt), 64'd20);
        check({tag, "_req_left"}, 64'(exp_req.size()), 64'd0);
        check({tag, "_data_left"}, 64'(exp_w.size() + exp_din.size()), 64'd0);
        check({tag, "_idle"}, 64'(dma_running), 64'd0);
    endtask

    initial begin
        host_rst = 1'b1; dma_start = 1'b0; dma_direction = 1'b0; dma_base = '0;
        dma_start1 = 1'b0; scan_dout1 = 64'hFEED_0000_0000_0001;
        m1.mem_req_ready = 1'b1; m1.mem_wready = 1'b1; m1.mem_bvalid = 1'b0;
        m1.mem_rvalid = 1'b0; m1.mem_rdata = '0;

        // Reset state
        do_reset();
        check("rst_running", 64'(dma_running), 64'd0);
        check("rst_done", 64'(dma_done), 64'd0);
        check("rst_scan_en", 64'(scan_en), 64'd0);
        check("rst_req_valid", 64'(m0.mem_req_valid), 64'd0);
        check("rst_wvalid", 64'(m0.mem_wvalid), 64'd0);
        check("rst_rready", 64'(m0.mem_rready), 64'd0);
        check("rst_addr_len", {m0.mem_req_addr, 24'd0, m0.mem_req_len}, 64'd0);
        check("rst_wdata", m0.mem_wdata, 64'd0);

        // 1: save, no back-pressure
        tb_load = 1'b0; bp_max = 0;
        push_save(32'h1000);
        start(1'b0, 32'h1000);
        check("t1_running", 64'(dma_running), 64'd1);
        wait_done("t1");

        // 2: load with random rvalid gaps
        do_reset();
        tb_load = 1'b1; bp_max = 3;
        exp_req.push_back('{addr: 32'h1000, len: 8'd15, wr: 1'b0});
        exp_req.push_back('{addr: 32'h1080, len: 8'd3, wr: 1'b0});
        for (int i = 0; i < 20; i++) exp_din.push_back(img_word(i));
        start(1'b1, 32'h1000);
        wait_done("t2");

        // 3: save with 0-5 cycle back-pressure on every channel
        do_reset();
        tb_load = 1'b0; bp_max = 5;
        push_save(32'h4000);
        start(1'b0, 32'h4000);
        wait_done("t3");

        // 4: second start mid-transfer is ignored
        do_reset();
        bp_max = 2;
        push_save(32'h1000);
        start(1'b0, 32'h1000);
        step(); step(); step();
        start(1'b1, 32'h5000);
        wait_done("t4");

        // 5: reset during DATA of burst 2, then a fresh transfer
        do_reset();
        bp_max = 0;
        push_save(32'h1000);
        start(1'b0, 32'h1000);
        for (int i = 0; i < 500 && scan_cnt < 17; i++) step();
        check("t5_in_burst2", 64'(m0.mem_wvalid), 64'd1);
        host_rst = 1'b1;
        #1;
        check("t5_rst_valids", {60'd0, m0.mem_req_valid, m0.mem_wvalid, m0.mem_rready, scan_en}, 64'd0);
        check("t5_rst_running", 64'(dma_running), 64'd0);
        step(); step();
        host_rst = 1'b0;
        exp_req.delete(); exp_w.delete(); exp_din.delete();
        push_save(32'h2000);
        start(1'b0, 32'h2000);
        wait_done("t5");

        // 6: CHAIN_WORDS=1, MAX_BURST=1 instance
        dma_start1 = 1'b1;
        step();
        dma_start1 = 1'b0;
        check("t6_req", {m1.mem_req_addr, 23'd0, m1.mem_req_valid, m1.mem_req_write, m1.mem_req_len},
              {32'h3000, 23'd0, 1'b1, 1'b1, 8'd0});
        step();
        check("t6_beat", {61'd0, m1.mem_wvalid, m1.mem_wlast, scan_en1}, 64'd7);
        check("t6_wdata", m1.mem_wdata, 64'hFEED_0000_0000_0001);
        step();
        check("t6_resp_wait", {61'd0, m1.mem_wvalid, dma_done1, dma_running1}, 64'd1);
        m1.mem_bvalid = 1'b1;
        step();
        m1.mem_bvalid = 1'b0;
        check("t6_done", 64'(dma_done1), 64'd1);
        step();
        check("t6_idle", {62'd0, dma_done1, dma_running1}, 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
